// File: rtl/rvb_issue_port_if.sv
// Handshake bundle between the upstream requester, the issue port and the functional unit.
// The slave view belongs to rvb_issue_port; the master view is the surrounding environment.
interface rvb_issue_port_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_insn;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [XLEN-1:0] req_rs3;

  logic            fu_din_valid;
  logic            fu_din_ready;
  logic [XLEN-1:0] fu_rs1;
  logic [XLEN-1:0] fu_rs2;
  logic [XLEN-1:0] fu_rs3;
  logic            fu_insn3;
  logic            fu_insn14;
  logic            fu_insn26;
  logic            fu_insn27;
  logic            fu_insn29;
  logic            fu_insn30;

  logic            fu_dout_valid;
  logic            fu_dout_ready;
  logic [XLEN-1:0] fu_dout_rd;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rd;
  logic [7:0]      rsp_tag;

  logic            busy;
  logic            err;

  modport slave (
    input  req_valid, req_insn, req_rs1, req_rs2, req_rs3,
    input  fu_din_ready, fu_dout_valid, fu_dout_rd, rsp_ready,
    output req_ready, fu_din_valid, fu_rs1, fu_rs2, fu_rs3,
    output fu_insn3, fu_insn14, fu_insn26, fu_insn27, fu_insn29, fu_insn30,
    output fu_dout_ready, rsp_valid, rsp_rd, rsp_tag, busy, err
  );

  modport master (
    output req_valid, req_insn, req_rs1, req_rs2, req_rs3,
    output fu_din_ready, fu_dout_valid, fu_dout_rd, rsp_ready,
    input  req_ready, fu_din_valid, fu_rs1, fu_rs2, fu_rs3,
    input  fu_insn3, fu_insn14, fu_insn26, fu_insn27, fu_insn29, fu_insn30,
    input  fu_dout_ready, rsp_valid, rsp_rd, rsp_tag, busy, err
  );
endinterface

// File: rtl/rvb_issue_port.sv
// Issue port: registers requests into a functional unit with a credit limit of OSTD
// operations, tags them in order and returns results through a single response register.
module rvb_issue_port #(
  parameter int XLEN = 32,
  parameter int OSTD = 4
) (
  input logic          clock,
  input logic          reset,
  rvb_issue_port_if.slave bus
);
  localparam int PTR_W = $clog2(OSTD);
  localparam int CNT_W = $clog2(OSTD) + 1;
  localparam int CMP_W = CNT_W + 1;
  localparam int INSN_POS [6] = '{3, 14, 26, 27, 29, 30};

  logic            issue_valid_reg;
  logic [XLEN-1:0] rs1_reg, rs2_reg, rs3_reg;
  logic [5:0]      insn_bits_reg;
  logic [7:0]      issue_tag_reg;
  logic [CNT_W-1:0] inflight_reg;
  logic [7:0]      seq_reg;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]      tag_mem [OSTD];
  logic            rsp_valid_reg;
  logic [XLEN-1:0] rsp_rd_reg;
  logic [7:0]      rsp_tag_reg;
  logic            err_reg;

  logic            accept, din_hs, dout_fire, dout_hs, spurious, idle;
  logic            req_ready_int, dout_ready_int;
  logic [CMP_W-1:0] credit_used, credit_limit;
  logic [5:0]      insn_sel;
  logic            unused_insn;

  // Bit 3 only has meaning for 64-bit operation; other instruction bits are not needed here.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_insn
      if (gi == 0 && XLEN != 64) begin : g_zero
        assign insn_sel[gi] = 1'b0;
      end else begin : g_pass
        assign insn_sel[gi] = bus.req_insn[INSN_POS[gi]];
      end
    end
  endgenerate
  assign unused_insn = ^bus.req_insn;

  always_comb begin
    idle           = (inflight_reg == '0);
    dout_ready_int = reset && (!rsp_valid_reg || bus.rsp_ready || idle);
    dout_fire      = bus.fu_dout_valid && dout_ready_int;
    dout_hs        = dout_fire && !idle;
    spurious       = dout_fire && idle;
    din_hs         = issue_valid_reg && bus.fu_din_ready;
    // A held issue register already owns a credit; a retiring result frees one this cycle.
    credit_used    = CMP_W'(inflight_reg) + CMP_W'(issue_valid_reg);
    credit_limit   = CMP_W'(OSTD) + CMP_W'(dout_hs);
    req_ready_int  = reset && (!issue_valid_reg || bus.fu_din_ready) &&
                     (credit_used < credit_limit);
    accept         = bus.req_valid && req_ready_int;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      issue_valid_reg <= 1'b0;
      rs1_reg         <= '0;
      rs2_reg         <= '0;
      rs3_reg         <= '0;
      insn_bits_reg   <= '0;
      issue_tag_reg   <= '0;
      inflight_reg    <= '0;
      seq_reg         <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rd_reg      <= '0;
      rsp_tag_reg     <= '0;
      err_reg         <= 1'b0;
    end else begin
      if (accept) begin
        issue_valid_reg <= 1'b1;
        rs1_reg         <= bus.req_rs1;
        rs2_reg         <= bus.req_rs2;
        rs3_reg         <= bus.req_rs3;
        insn_bits_reg   <= insn_sel;
        issue_tag_reg   <= seq_reg;
        seq_reg         <= seq_reg + 8'd1;
      end else if (din_hs) begin
        issue_valid_reg <= 1'b0;
      end

      if (din_hs) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (dout_hs) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

      case ({din_hs, dout_hs})
        2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
        2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
        default: inflight_reg <= inflight_reg;
      endcase

      // Completion is in order, so the FIFO head always names the returning result.
      if (dout_hs) begin
        rsp_valid_reg <= 1'b1;
        rsp_rd_reg    <= bus.fu_dout_rd;
        rsp_tag_reg   <= tag_mem[rd_ptr_reg];
      end else if (bus.rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end

      if (spurious) err_reg <= 1'b1;
    end
  end

  // Tag storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (din_hs) tag_mem[wr_ptr_reg] <= issue_tag_reg;
  end

  assign bus.req_ready     = req_ready_int;
  assign bus.fu_din_valid  = issue_valid_reg;
  assign bus.fu_rs1        = rs1_reg;
  assign bus.fu_rs2        = rs2_reg;
  assign bus.fu_rs3        = rs3_reg;
  assign bus.fu_insn3      = insn_bits_reg[0];
  assign bus.fu_insn14     = insn_bits_reg[1];
  assign bus.fu_insn26     = insn_bits_reg[2];
  assign bus.fu_insn27     = insn_bits_reg[3];
  assign bus.fu_insn29     = insn_bits_reg[4];
  assign bus.fu_insn30     = insn_bits_reg[5];
  assign bus.fu_dout_ready = dout_ready_int;
  assign bus.rsp_valid     = rsp_valid_reg;
  assign bus.rsp_rd        = rsp_rd_reg;
  assign bus.rsp_tag       = rsp_tag_reg;
  assign bus.busy          = issue_valid_reg || rsp_valid_reg || !idle;
  assign bus.err           = err_reg;
endmodule
